// File: rtl/adc_udp_regs_pkg.sv
// Shared types and helpers for the ADC-to-UDP AXI4-Lite register bank.
package adc_udp_regs_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Sized for the widest supported bus; narrower callers zero-extend and truncate.
  function automatic logic [63:0] strb_merge(input logic [63:0] old,
                                             input logic [63:0] wdata,
                                             input logic [7:0]  wstrb);
    logic [63:0] merged;
    merged = old;
    for (int b = 0; b < 8; b++) begin
      if (wstrb[b]) merged[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/adc_udp_axil_regs_if.sv
// AXI4-Lite bus bundle for the ADC-to-UDP register bank.
interface adc_udp_axil_regs_if #(
  parameter int DW = 32,
  parameter int AW = 6
);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/adc_udp_axil_regs.sv
// AXI4-Lite register bank: R/W control regs, R/O status regs and an optional
// write-one-to-pulse command word (enabled by ADC_UDP_REG_PULSE_EN).
module adc_udp_axil_regs
  import adc_udp_regs_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_RW_REGS        = 8,
  parameter int NUM_RO_REGS        = 4
) (
  input  logic ACLK,
  input  logic ARESET,
  adc_udp_axil_regs_if.slave s_axi,
  output logic [NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0] ctrl_regs,
  input  logic [((NUM_RO_REGS > 0) ? NUM_RO_REGS : 1)*C_S_AXI_DATA_WIDTH-1:0] status_in,
  output logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_pulse
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int ADDR_LSB = $clog2(DW/8);
  localparam int IW       = AW - ADDR_LSB;
  localparam int P_IDX    = NUM_RW_REGS + NUM_RO_REGS;

`ifdef ADC_UDP_REG_PULSE_EN
  localparam logic PULSE_EN = 1'b1;
`else
  localparam logic PULSE_EN = 1'b0;
`endif

  wr_state_t wr_state_reg, wr_state_next;
  rd_state_t rd_state_reg, rd_state_next;

  logic [DW-1:0] ctrl_mem [NUM_RW_REGS];

  logic          awready_reg, arready_reg;
  logic          bvalid_reg, rvalid_reg;
  logic [1:0]    bresp_reg, rresp_reg;
  logic [DW-1:0] rdata_reg;

  logic [IW-1:0] wr_idx, rd_idx;
  logic          wr_fire, rd_fire;
  logic          wr_is_rw, wr_is_p, wr_ok;
  logic          rd_mapped;
  logic [DW-1:0] rd_value;
  logic          unused_ok;

  assign wr_idx = s_axi.awaddr[AW-1:ADDR_LSB];
  assign rd_idx = s_axi.araddr[AW-1:ADDR_LSB];

  assign wr_is_rw = 32'(wr_idx) < 32'(NUM_RW_REGS);
  assign wr_is_p  = PULSE_EN && (32'(wr_idx) == 32'(P_IDX));
  assign wr_ok    = wr_is_rw || wr_is_p;

  assign rd_mapped = (32'(rd_idx) < 32'(P_IDX)) ||
                     (PULSE_EN && (32'(rd_idx) == 32'(P_IDX)));

  assign unused_ok = ^{s_axi.awprot, s_axi.arprot,
                       s_axi.awaddr[ADDR_LSB-1:0], s_axi.araddr[ADDR_LSB-1:0]};

  // Write channel FSM
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) wr_state_reg <= W_IDLE;
    else        wr_state_reg <= wr_state_next;
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    wr_fire       = 1'b0;
    case (wr_state_reg)
      W_IDLE: begin
        if (awready_reg && s_axi.awvalid && s_axi.wvalid) begin
          wr_fire       = 1'b1;
          wr_state_next = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi.bready) wr_state_next = W_IDLE;
      end
      default: wr_state_next = W_IDLE;
    endcase
  end

  // READY is a one-cycle pulse raised only after both address and data are seen.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      awready_reg <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
    end else begin
      awready_reg <= (wr_state_reg == W_IDLE) && !awready_reg &&
                     s_axi.awvalid && s_axi.wvalid;
      if (wr_fire) begin
        bvalid_reg <= 1'b1;
        bresp_reg  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (wr_state_reg == W_RESP && s_axi.bready) begin
        bvalid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_RW_REGS; i++) ctrl_mem[i] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < NUM_RW_REGS; i++) begin
        if (32'(wr_idx) == 32'(i)) begin
          ctrl_mem[i] <= DW'(strb_merge(64'(ctrl_mem[i]), 64'(s_axi.wdata),
                                        8'(s_axi.wstrb)));
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RW_REGS; gi++) begin : g_ctrl_out
    assign ctrl_regs[gi*DW +: DW] = ctrl_mem[gi];
  end

`ifdef ADC_UDP_REG_PULSE_EN
  logic [DW-1:0] pulse_reg;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)                  pulse_reg <= '0;
    else if (wr_fire && wr_is_p) pulse_reg <= DW'(strb_merge(64'd0, 64'(s_axi.wdata),
                                                             8'(s_axi.wstrb)));
    else                         pulse_reg <= '0;
  end

  assign ctrl_pulse = pulse_reg;
`else
  assign ctrl_pulse = '0;
`endif

  // Read channel FSM, independent of the write side
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) rd_state_reg <= R_IDLE;
    else        rd_state_reg <= rd_state_next;
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    rd_fire       = 1'b0;
    case (rd_state_reg)
      R_IDLE: begin
        if (arready_reg && s_axi.arvalid) begin
          rd_fire       = 1'b1;
          rd_state_next = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi.rready) rd_state_next = R_IDLE;
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  // Pulse index and unmapped indices both fall through to zero.
  always_comb begin
    rd_value = '0;
    for (int i = 0; i < NUM_RW_REGS; i++) begin
      if (32'(rd_idx) == 32'(i)) rd_value = ctrl_mem[i];
    end
    for (int i = 0; i < NUM_RO_REGS; i++) begin
      if (32'(rd_idx) == 32'(NUM_RW_REGS + i)) rd_value = status_in[i*DW +: DW];
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rresp_reg   <= RESP_OKAY;
      rdata_reg   <= '0;
    end else begin
      arready_reg <= (rd_state_reg == R_IDLE) && !arready_reg && s_axi.arvalid;
      if (rd_fire) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_value;
        rresp_reg  <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
      end else if (rd_state_reg == R_DATA && s_axi.rready) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  assign s_axi.awready = awready_reg;
  assign s_axi.wready  = awready_reg;
  assign s_axi.bvalid  = bvalid_reg;
  assign s_axi.bresp   = bresp_reg;
  assign s_axi.arready = arready_reg;
  assign s_axi.rvalid  = rvalid_reg;
  assign s_axi.rresp   = rresp_reg;
  assign s_axi.rdata   = rdata_reg;

endmodule

// File: tb/tb_adc_udp_axil_regs.sv
// Directed self-checking bench for adc_udp_axil_regs (default parameters).
module tb_adc_udp_axil_regs;

  logic clk = 1'b0;
  logic rst = 1'b1;

  adc_udp_axil_regs_if #(.DW(32), .AW(6)) bus ();

  logic [8*32-1:0] ctrl_regs;
  logic [4*32-1:0] status_in;
  logic [31:0]     ctrl_pulse;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] pulse_at_resp;
  logic [31:0] pulse_after;

  always #5 clk = ~clk;

  adc_udp_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6),
    .NUM_RW_REGS(8),
    .NUM_RO_REGS(4)
  ) dut (
    .ACLK(clk),
    .ARESET(rst),
    .s_axi(bus.slave),
    .ctrl_regs(ctrl_regs),
    .status_in(status_in),
    .ctrl_pulse(ctrl_pulse)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic ok;
    @(posedge clk); #1;
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    bus.bready = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bus.awready) begin ok = 1'b1; break; end
    end
    check("aw_ready_seen", ok, 1'b1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("bvalid_after_hs", bus.bvalid, 1'b1);
    resp = bus.bresp;
    pulse_at_resp = ctrl_pulse;
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    pulse_after = ctrl_pulse;
    check("bvalid_cleared", bus.bvalid, 1'b0);
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    logic ok;
    @(posedge clk); #1;
    bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bus.arready) begin ok = 1'b1; break; end
    end
    check("ar_ready_seen", ok, 1'b1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    check("rvalid_after_hs", bus.rvalid, 1'b1);
    data = bus.rdata;
    resp = bus.rresp;
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
    check("rvalid_cleared", bus.rvalid, 1'b0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rsp;
    logic [31:0] exp_tbl [12];
    logic        ok;

    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    status_in = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", bus.awready, 1'b0);
    check("rst_bvalid", bus.bvalid, 1'b0);
    check("rst_rvalid", bus.rvalid, 1'b0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_bresp", bus.bresp, 2'b00);
    check("rst_ctrl_regs", ctrl_regs, 256'h0);
    check("rst_pulse", ctrl_pulse, 32'h0);
    rst = 1'b0;

    // Post-reset readback of all mapped indices
    for (int i = 0; i < 8; i++) exp_tbl[i] = 32'h0;
    exp_tbl[8]  = 32'h1111_0000;
    exp_tbl[9]  = 32'h2222_0001;
    exp_tbl[10] = 32'h3333_0002;
    exp_tbl[11] = 32'h4444_0003;
    for (int i = 0; i < 12; i++) begin
      axi_read(6'(i*4), rd, rsp);
      $display("read idx %0d data %h resp %0d", i, rd, rsp);
      check("init_rdata", rd, exp_tbl[i]);
      check("init_rresp", rsp, 2'b00);
    end

    // Byte-strobed write to index 3
    axi_write(6'd12, 32'h1122_3344, 4'hF, rsp);
    check("w3_full_resp", rsp, 2'b00);
    axi_write(6'd12, 32'hDEAD_BEEF, 4'b0101, rsp);
    check("w3_strb_resp", rsp, 2'b00);
    axi_read(6'd13, rd, rsp);
    $display("read idx 3 data %h resp %0d", rd, rsp);
    check("w3_readback", rd, 32'h11AD_33EF);
    check("w3_ctrl_regs", ctrl_regs[127:96], 32'h11AD_33EF);

    // AWVALID early, WVALID late, BREADY held low
    @(posedge clk); #1;
    bus.awaddr = 6'd20; bus.awvalid = 1'b1; bus.wvalid = 1'b0; bus.bready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      check("aw_only_awready", bus.awready, 1'b0);
      check("aw_only_wready", bus.wready, 1'b0);
    end
    bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    check("both_awready", bus.awready, 1'b1);
    check("both_wready", bus.wready, 1'b1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("late_bvalid", bus.bvalid, 1'b1);
    check("resp_awready_low", bus.awready, 1'b0);
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      check("bvalid_hold", bus.bvalid, 1'b1);
      check("bresp_hold", bus.bresp, 2'b00);
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    check("late_bvalid_clr", bus.bvalid, 1'b0);
    $display("write idx 5 data cafef00d (late wvalid)");
    check("late_ctrl_regs", ctrl_regs[191:160], 32'hCAFE_F00D);

    // Status write rejected; unmapped read
    axi_write(6'd36, 32'h0000_0001, 4'hF, rsp);
    $display("write idx 9 resp %0d", rsp);
    check("ro_write_resp", rsp, 2'b10);
    axi_read(6'd36, rd, rsp);
    check("ro_unchanged", rd, 32'h2222_0001);
    check("ro_read_resp", rsp, 2'b00);
    axi_read(6'd56, rd, rsp);
    $display("read idx 14 data %h resp %0d", rd, rsp);
    check("unmapped_rdata", rd, 32'h0);
    check("unmapped_rresp", rsp, 2'b10);

    // Pulse register at index 12
    axi_write(6'd48, 32'h0000_0005, 4'hF, rsp);
    $display("write idx 12 resp %0d pulse %h then %h", rsp, pulse_at_resp, pulse_after);
`ifdef ADC_UDP_REG_PULSE_EN
    check("pulse_resp", rsp, 2'b00);
    check("pulse_value", pulse_at_resp, 32'h5);
    check("pulse_cleared", pulse_after, 32'h0);
    axi_read(6'd48, rd, rsp);
    check("pulse_rdata", rd, 32'h0);
    check("pulse_rresp", rsp, 2'b00);
`else
    check("pulse_resp", rsp, 2'b10);
    check("pulse_value", pulse_at_resp, 32'h0);
    check("pulse_cleared", pulse_after, 32'h0);
    axi_read(6'd48, rd, rsp);
    check("pulse_rresp", rsp, 2'b10);
`endif
    check("ctrl_unaffected", ctrl_regs[127:96], 32'h11AD_33EF);

    // Reset while BVALID pending
    @(posedge clk); #1;
    bus.awaddr = 6'd8; bus.awvalid = 1'b1;
    bus.wdata = 32'h0000_0077; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bus.awready) begin ok = 1'b1; break; end
    end
    check("rst_case_ready", ok, 1'b1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("rst_case_bvalid", bus.bvalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_bvalid_drop", bus.bvalid, 1'b0);
    check("async_ctrl_clear", ctrl_regs, 256'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    axi_read(6'd12, rd, rsp);
    $display("read idx 3 after reset data %h resp %0d", rd, rsp);
    check("post_rst_idx3", rd, 32'h0);
    axi_read(6'd8, rd, rsp);
    check("post_rst_idx2", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
